// File: rtl/crc16_cerceveleyici.sv
// CRC-16/CCITT frame packer: forwards payload bytes, then appends CRC high and low bytes.
// The low CRC byte carries the frame-end flag. A one-entry output register decouples the
// payload input from the serial-line driver downstream.
module crc16_cerceveleyici #(
    parameter logic [15:0] CRC_BASLANGIC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  s_byte_i,
    input  logic        s_gecerli_i,
    input  logic        s_son_i,
    output logic        s_hazir_o,
    output logic [7:0]  m_byte_o,
    output logic        m_gecerli_o,
    output logic        m_son_o,
    input  logic        m_hazir_i,
    output logic [15:0] crc_o,
    output logic        crc_gecerli_o,
    output logic [15:0] bayt_sayisi_o
);

    typedef enum logic [1:0] {
        StVeri,
        StCrcH,
        StCrcL
    } durum_e;

    durum_e      durum_q, durum_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] sayac_q, sayac_d;
    logic [7:0]  bayt_q, bayt_d;
    logic        gecerli_q, gecerli_d;
    logic        son_q, son_d;
    logic [15:0] crc_cikis_q, crc_cikis_d;
    logic [15:0] sayi_q, sayi_d;
    logic        crc_puls_q, crc_puls_d;

    logic slot_bos;
    logic giris_aktarim;

    // One CRC-16/CCITT step per input bit, MSB first.
    function automatic logic [15:0] crc_bayt(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[7-i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Handshake qualifiers; s_hazir_o follows m_hazir_i combinationally.
    always_comb begin
        slot_bos      = !gecerli_q || m_hazir_i;
        s_hazir_o     = (durum_q == StVeri) && slot_bos;
        giris_aktarim = s_gecerli_i && s_hazir_o;
    end

    // Next-state: payload loading, CRC byte emission and end-of-frame bookkeeping.
    always_comb begin
        durum_d     = durum_q;
        crc_d       = crc_q;
        sayac_d     = sayac_q;
        bayt_d      = bayt_q;
        gecerli_d   = gecerli_q;
        son_d       = son_q;
        crc_cikis_d = crc_cikis_q;
        sayi_d      = sayi_q;
        crc_puls_d  = 1'b0;

        // Drained slot with nothing new loaded below goes empty.
        if (gecerli_q && m_hazir_i) begin
            gecerli_d = 1'b0;
        end

        unique case (durum_q)
            StVeri: begin
                if (giris_aktarim) begin
                    bayt_d    = s_byte_i;
                    gecerli_d = 1'b1;
                    son_d     = 1'b0;
                    crc_d     = crc_bayt(crc_q, s_byte_i);
                    sayac_d   = sayac_q + 16'd1;
                    if (s_son_i) begin
                        durum_d = StCrcH;
                    end
                end
            end
            StCrcH: begin
                if (slot_bos) begin
                    bayt_d    = crc_q[15:8];
                    gecerli_d = 1'b1;
                    son_d     = 1'b0;
                    durum_d   = StCrcL;
                end
            end
            StCrcL: begin
                if (slot_bos) begin
                    bayt_d      = crc_q[7:0];
                    gecerli_d   = 1'b1;
                    son_d       = 1'b1;
                    crc_cikis_d = crc_q;
                    sayi_d      = sayac_q;
                    crc_puls_d  = 1'b1;
                    crc_d       = CRC_BASLANGIC;
                    sayac_d     = 16'd0;
                    durum_d     = StVeri;
                end
            end
            default: begin
                durum_d = StVeri;
            end
        endcase
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q     <= StVeri;
            crc_q       <= CRC_BASLANGIC;
            sayac_q     <= 16'd0;
            bayt_q      <= 8'd0;
            gecerli_q   <= 1'b0;
            son_q       <= 1'b0;
            crc_cikis_q <= 16'd0;
            sayi_q      <= 16'd0;
            crc_puls_q  <= 1'b0;
        end else begin
            durum_q     <= durum_d;
            crc_q       <= crc_d;
            sayac_q     <= sayac_d;
            bayt_q      <= bayt_d;
            gecerli_q   <= gecerli_d;
            son_q       <= son_d;
            crc_cikis_q <= crc_cikis_d;
            sayi_q      <= sayi_d;
            crc_puls_q  <= crc_puls_d;
        end
    end

    // Output drive straight from registers.
    always_comb begin
        m_byte_o      = bayt_q;
        m_gecerli_o   = gecerli_q;
        m_son_o       = son_q;
        crc_o         = crc_cikis_q;
        crc_gecerli_o = crc_puls_q;
        bayt_sayisi_o = sayi_q;
    end

endmodule
